// File: rtl/kr_pkg.sv
// Shared types and helpers for the Knight Rider LED scanner.
// Imported by the tick generator and the top-level position FSM.
package kr_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Prescaler counter width; never narrower than one bit.
  function automatic int presc_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/kr_tick_gen.sv
// Prescaler for the scanner: counts 0..STEP_CYCLES-1 and flags the wrap cycle.
// tick is high during the cycle whose closing edge wraps the counter.
module kr_tick_gen
  import kr_pkg::*;
#(
  parameter int STEP_CYCLES = 4_000_000
) (
  input  logic clki,
  input  logic reset,
  output logic tick
);

  localparam int             W    = presc_width(STEP_CYCLES);
  localparam logic [W-1:0]   LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With STEP_CYCLES=1 the counter sits at zero and tick stays high.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/knight_rider.sv
// 8-LED style scanner: a single lit LED bounces between LSB and MSB,
// advancing one position per prescaler tick; leds is a registered one-hot.
module knight_rider
  import kr_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int STEP_CYCLES = 4_000_000
) (
  input  logic                clki,
  input  logic                reset,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int            PW       = $clog2(NUM_LEDS);
  localparam logic [PW-1:0] LAST_POS = PW'(NUM_LEDS - 1);
  localparam logic [PW:0]   NUM_EXT  = (PW+1)'(NUM_LEDS);

  logic tick;

  kr_tick_gen #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_tick_gen (
    .clki  (clki),
    .reset (reset),
    .tick  (tick)
  );

  logic [PW-1:0]       pos_q;
  logic [PW-1:0]       pos_d;
  dir_t                dir_q;
  dir_t                dir_d;
  logic [NUM_LEDS-1:0] leds_q;
  logic [NUM_LEDS-1:0] leds_d;
  logic [PW:0]         pos_ext;

  assign pos_ext = {1'b0, pos_q};

  // Endpoints turn around immediately so they are never held twice.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (pos_ext >= NUM_EXT) begin
      pos_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      case (dir_q)
        DIR_UP: begin
          if (pos_q == LAST_POS) begin
            dir_d = DIR_DOWN;
            pos_d = pos_q - PW'(1);
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
        DIR_DOWN: begin
          if (pos_q == '0) begin
            dir_d = DIR_UP;
            pos_d = PW'(1);
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      endcase
    end
  end

  // Decode from the next position so leds lines up with pos_q.
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_decode
      assign leds_d[gi] = (pos_d == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clki) begin
    if (reset) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      leds_q <= NUM_LEDS'(1);
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_knight_rider.sv
// Bench for knight_rider: two builds (STEP_CYCLES=2 and 1) share clock and reset,
// checked every cycle against a position-from-step-count reference.
module tb_knight_rider;

  localparam int N = 8;
  localparam int PERIOD = 2 * (N - 1);

  logic         clki  = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] leds2;
  logic [N-1:0] leds1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #10 clki = ~clki;

  knight_rider #(
    .NUM_LEDS    (N),
    .STEP_CYCLES (2)
  ) dut2 (
    .clki  (clki),
    .reset (reset),
    .leds  (leds2)
  );

  knight_rider #(
    .NUM_LEDS    (N),
    .STEP_CYCLES (1)
  ) dut1 (
    .clki  (clki),
    .reset (reset),
    .leds  (leds1)
  );

  // Position after a given number of steps along the bouncing sequence.
  function automatic int pos_at(input int steps);
    int k;
    k = steps % PERIOD;
    return (k < N) ? k : PERIOD - k;
  endfunction

  function automatic logic [N-1:0] onehot_of(input int pos);
    logic [N-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply reset value, advance the reference, compare on the falling edge.
  task automatic cycle(input logic rst);
    logic [N-1:0] prev2;
    prev2 = leds2;
    reset = rst;
    @(posedge clki);
    cyc = rst ? 0 : cyc + 1;
    @(negedge clki);
    check_eq("leds_s2", 32'(leds2), 32'(onehot_of(pos_at(cyc / 2))));
    check_eq("leds_s1", 32'(leds1), 32'(onehot_of(pos_at(cyc))));
    check_eq("onehot_s2", 32'($onehot(leds2)), 32'd1);
    check_eq("onehot_s1", 32'($onehot(leds1)), 32'd1);
    if (!rst && (cyc % 2 == 1)) begin
      check_eq("hold_s2", 32'(leds2), 32'(prev2));
    end
    $display("cyc %0d rst %0b leds_s2 %02h leds_s1 %02h", cyc, rst, leds2, leds1);
  endtask

  initial begin
    bit found;

    // Reset held for two edges.
    cycle(1'b1);
    cycle(1'b1);
    check_eq("reset_hold", 32'(leds2), 32'h01);

    // Free run beyond one full period to see the wrap back to 01, 02.
    for (int i = 0; i < 2 * PERIOD * 2 + 4; i++) begin
      cycle(1'b0);
    end

    // Wait (bounded) until leds=20 while moving down, then reset for one edge.
    found = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !found; i++) begin
      if (onehot_of(pos_at(cyc / 2)) == N'(8'h20) && (cyc / 2) % PERIOD >= N) begin
        found = 1'b1;
      end else begin
        cycle(1'b0);
      end
    end
    check_eq("wait_20_down", 32'(found), 32'd1);
    check_eq("at_20_down", 32'(leds2), 32'h20);
    cycle(1'b1);
    check_eq("mid_reset_01", 32'(leds2), 32'h01);
    cycle(1'b0);
    cycle(1'b0);
    check_eq("mid_reset_02", 32'(leds2), 32'h02);

    // Random run with sporadic reset pulses.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
